// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one shared memory bus to the IF or MEM port, with MEM priority, IF anti-starvation and registered bus/status outputs
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_re,
  input  logic [31:0] if_addr,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata_o,
  output logic [1:0]  busy_o,
  output logic [1:0]  done_o
);
  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_MEM} state_t;
  state_t r_state;
  logic [2:0] r_starve;
  logic w_if_elig, w_mem_elig, w_pick_if, w_pick_mem;
  assign w_if_elig  = if_re & ~done_o[0];
  assign w_mem_elig = (mem_re | mem_we) & ~done_o[1];
  assign w_pick_if  = w_if_elig & (~w_mem_elig | (r_starve >= 3'd4));
  assign w_pick_mem = w_mem_elig & ~w_pick_if;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_starve  <= 3'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_sel   <= 4'd0;
      bus_wdata <= 32'd0;
      rdata_o   <= 32'd0;
      busy_o    <= 2'b00;
      done_o    <= 2'b00;
    end else begin
      done_o <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_pick_if) begin
            r_state   <= GRANT_IF;
            r_starve  <= 3'd0;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_sel   <= 4'hF;
            bus_wdata <= 32'd0;
            busy_o    <= 2'b01;
          end else if (w_pick_mem) begin
            r_state   <= GRANT_MEM;
            r_starve  <= if_re ? r_starve + 3'd1 : 3'd0;
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_sel   <= mem_we ? mem_sel : 4'hF;
            bus_wdata <= mem_we ? mem_wdata : 32'd0;
            busy_o    <= 2'b10;
          end
        end
        default: begin
          if (bus_ack) begin
            r_state   <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_sel   <= 4'd0;
            bus_wdata <= 32'd0;
            busy_o    <= 2'b00;
            done_o    <= {r_state == GRANT_MEM, r_state == GRANT_IF};
            rdata_o   <= bus_we ? rdata_o : bus_rdata;
          end
        end
      endcase
    end
  end
endmodule
